// File: rtl/simon_seq_pkg.sv
// Shared types and defaults for the Simon sequence store.
package simon_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PLAY  = 2'd1,
        ST_CHECK = 2'd2
    } state_t;

    localparam int SEQ_SYM_W = 2;
    localparam int SEQ_DEPTH = 16;

    typedef logic [SEQ_SYM_W-1:0] sym_t;

endpackage

// File: rtl/seq_ram.sv
// DEPTH x SYM_W flop array: synchronous write, combinational read.
module seq_ram #(
    parameter int SYM_W  = 2,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              i_clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [SYM_W-1:0]  i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [SYM_W-1:0]  o_rdata
);

    logic [SYM_W-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/seq_store_ctrl.sv
// Simon sequence store: append, valid/ready playback and player-input checking
// against a stored symbol sequence of up to DEPTH entries.
module seq_store_ctrl
    import simon_seq_pkg::*;
#(
    parameter int SYM_W = SEQ_SYM_W,
    parameter int DEPTH = SEQ_DEPTH,
    parameter int LEN_W = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             append,
    input  logic [SYM_W-1:0] append_sym,
    input  logic             play,
    input  logic             check,
    output logic             out_valid,
    output logic [SYM_W-1:0] out_sym,
    input  logic             out_ready,
    input  logic             in_valid,
    input  logic [SYM_W-1:0] in_sym,
    output logic             match,
    output logic             mismatch,
    output logic             done,
    output logic             overflow,
    output logic [LEN_W-1:0] length,
    output logic             full,
    output logic             busy
);

    localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [LEN_W-1:0] r_len;
    logic [LEN_W-1:0] r_idx;
    logic [LEN_W-1:0] w_len_nxt;
    logic [LEN_W-1:0] w_idx_nxt;
    logic [LEN_W-1:0] w_last_idx;
    logic             r_match;
    logic             r_mismatch;
    logic             r_done;
    logic             r_overflow;
    logic             w_match_nxt;
    logic             w_mismatch_nxt;
    logic             w_done_nxt;
    logic             w_overflow_nxt;
    logic             w_we;
    logic             w_full;
    logic             w_empty;
    logic             w_is_last;
    logic [SYM_W-1:0] w_rdata;

    seq_ram #(
        .SYM_W  (SYM_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .i_clk   (clock),
        .i_we    (w_we),
        .i_waddr (r_len[ADDR_W-1:0]),
        .i_wdata (append_sym),
        .i_raddr (r_idx[ADDR_W-1:0]),
        .o_rdata (w_rdata)
    );

    assign w_full     = (r_len == LEN_W'(DEPTH));
    assign w_empty    = (r_len == '0);
    assign w_last_idx = r_len - LEN_W'(1);
    assign w_is_last  = (r_idx == w_last_idx);

    always_comb begin
        w_state_nxt    = r_state;
        w_len_nxt      = r_len;
        w_idx_nxt      = r_idx;
        w_match_nxt    = 1'b0;
        w_mismatch_nxt = 1'b0;
        w_done_nxt     = 1'b0;
        w_overflow_nxt = 1'b0;
        w_we           = 1'b0;

        if (clear) begin
            w_state_nxt = ST_IDLE;
            w_len_nxt   = '0;
            w_idx_nxt   = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    // Priority append > play > check; losers are dropped.
                    if (append) begin
                        if (w_full) begin
                            w_overflow_nxt = 1'b1;
                        end else begin
                            w_we      = 1'b1;
                            w_len_nxt = r_len + LEN_W'(1);
                        end
                    end else if (play || check) begin
                        w_idx_nxt = '0;
                        if (w_empty) begin
                            w_done_nxt = 1'b1;
                        end else begin
                            w_state_nxt = play ? ST_PLAY : ST_CHECK;
                        end
                    end
                end
                ST_PLAY: begin
                    if (out_ready) begin
                        if (w_is_last) begin
                            w_done_nxt  = 1'b1;
                            w_state_nxt = ST_IDLE;
                            w_idx_nxt   = '0;
                        end else begin
                            w_idx_nxt = r_idx + LEN_W'(1);
                        end
                    end
                end
                ST_CHECK: begin
                    if (in_valid) begin
                        if (in_sym == w_rdata) begin
                            w_match_nxt = 1'b1;
                            if (w_is_last) begin
                                w_done_nxt  = 1'b1;
                                w_state_nxt = ST_IDLE;
                                w_idx_nxt   = '0;
                            end else begin
                                w_idx_nxt = r_idx + LEN_W'(1);
                            end
                        end else begin
                            w_mismatch_nxt = 1'b1;
                            w_state_nxt    = ST_IDLE;
                        end
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_len      <= '0;
            r_idx      <= '0;
            r_match    <= 1'b0;
            r_mismatch <= 1'b0;
            r_done     <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_len      <= w_len_nxt;
            r_idx      <= w_idx_nxt;
            r_match    <= w_match_nxt;
            r_mismatch <= w_mismatch_nxt;
            r_done     <= w_done_nxt;
            r_overflow <= w_overflow_nxt;
        end
    end

    // Playback data reads straight from the array at the current index, so it
    // holds while stalled and follows the index with no bubble.
    assign out_valid = (r_state == ST_PLAY);
    assign out_sym   = out_valid ? w_rdata : '0;
    assign match     = r_match;
    assign mismatch  = r_mismatch;
    assign done      = r_done;
    assign overflow  = r_overflow;
    assign length    = r_len;
    assign full      = w_full;
    assign busy      = (r_state != ST_IDLE);

endmodule

// File: doc/seq_store_ctrl.md
Name: seq_store_ctrl

Overview:
Parametrised sequence memory for the Simon game. It is the successor to the fixed 2-bit single-port number store.
- Holds up to DEPTH symbols with a hardware length counter.
- Appends a new symbol at the tail.
- Plays the stored sequence back over a valid/ready stream.
- Checks a player's input stream against the stored sequence, reporting match, mismatch and completion.
- Sits between the game FSM (commands), the LED/tone driver (playback) and the button decoder (player input).

Parameters:
SYM_W, 2, width of one symbol (2 gives 4 colours)
DEPTH, 16, maximum sequence length in symbols
LEN_W, $clog2(DEPTH+1), derived width of length/index; not to be overridden

Ports:
clock  in  1  single clock; all logic on rising edge
reset_n  in  1  synchronous, active-low reset
clear  in  1  empty the sequence; abort any operation
append  in  1  add append_sym at the tail
append_sym  in  SYM_W  symbol to append
play  in  1  start playback of entries 0..length-1
check  in  1  start checking player input
out_valid  out  1  playback symbol valid
out_sym  out  SYM_W  playback symbol
out_ready  in  1  playback consumer ready
in_valid  in  1  player symbol valid (always accepted in CHECK)
in_sym  in  SYM_W  player symbol
match  out  1  one-cycle pulse: last player symbol correct
mismatch  out  1  one-cycle pulse: last player symbol wrong
done  out  1  one-cycle pulse: playback or check finished successfully
overflow  out  1  one-cycle pulse: append attempted while full
length  out  LEN_W  current number of stored symbols
full  out  1  length == DEPTH
busy  out  1  state != IDLE

Behaviour:
- Reset (reset_n low at a clock edge): state IDLE, length 0, index 0. All outputs 0: out_valid, out_sym, match, mismatch, done, overflow, busy. Array contents are not reset and are don't-care beyond length. Reset mid-PLAY or mid-CHECK aborts with no done pulse.
- States: IDLE, PLAY, CHECK. Commands are sampled only in IDLE.
- Command priority in IDLE: clear > append > play > check. Lower-priority commands in the same cycle are dropped.
- clear: accepted in any state. Next cycle: length 0, state IDLE, out_valid 0, no pulse.
- append in IDLE:
  - If length < DEPTH: mem[length] <= append_sym and length increments next cycle.
  - If full: overflow pulses for one cycle next cycle; nothing else changes.
  - full updates combinationally from the registered length.
- play in IDLE, sampled at edge T:
  - If length == 0: done pulses in cycle T+1 and the block stays IDLE.
  - Otherwise: in cycle T+1 the state is PLAY, out_valid=1, out_sym=mem[0], index=0.
  - Each handshake (out_valid && out_ready at an edge) advances index. out_sym = mem[index+1] in the following cycle, with zero bubbles.
  - out_sym stays stable while out_valid && !out_ready.
  - On the handshake of index == length-1: next cycle out_valid=0, done=1, state IDLE.
- check in IDLE, sampled at edge T:
  - If length == 0: done pulses in cycle T+1 and the block stays IDLE.
  - Otherwise the state is CHECK from T+1, index=0.
  - Each in_valid cycle compares in_sym with mem[index]; the result pulse appears next cycle.
  - Equal and index < length-1: match=1, index++.
  - Equal and index == length-1: match=1 and done=1 in the same cycle, state IDLE.
  - Not equal: mismatch=1, state IDLE, index not advanced.
- Commands (other than clear) in PLAY/CHECK are ignored. in_valid outside CHECK is ignored.
- match, mismatch, done and overflow are registered and mutually consistent: never mismatch together with match or done.
- Index and length arithmetic are unsigned LEN_W bits. length never exceeds DEPTH and never wraps.

Decomposition:
- Package simon_seq_pkg holds:
  - state enum (IDLE, PLAY, CHECK)
  - default SYM_W and DEPTH localparams
  - symbol typedef for the default width
- One sub-module, seq_ram:
  - DEPTH x SYM_W flop array
  - synchronous write port (we, waddr, wdata)
  - combinational read port (raddr, rdata)
- seq_store_ctrl holds the FSM, counters and output registers.

Test Plan:
- Reset then append 3,1,2 on consecutive cycles, then play with out_ready=1 -> length=3. out_sym 3,1,2 on three consecutive out_valid cycles, then done pulse, busy=0.
- Same sequence, play with out_ready toggling 1,0,1,0,1 -> each symbol held stable while stalled; exactly 3 handshakes; done after the third.
- Check with in_sym 3,1,2 (gaps of idle cycles between) -> match, match, then match+done; no mismatch.
- Check with in_sym 3,0 -> match, then mismatch the following cycle; state IDLE; a later play still replays 3,1,2.
- Append 16 symbols (DEPTH=16), then a 17th -> full=1, overflow pulse, length=16, mem[15] unchanged. Then clear -> length=0, full=0. Then play -> done at T+1 with out_valid never high.
- Mid-PLAY after 1 handshake, assert reset_n=0 for one cycle -> next cycle out_valid=0, length=0, busy=0, no done pulse. Repeat with clear instead of reset -> identical outputs.
